// File: rtl/pipe_adder_pkg.sv
// Shared types and parameter checking for the pipelined carry-select adder.
package pipe_adder_pkg;

  // Carry and valid travelling together from one stage to the next.
  typedef struct packed {
    logic carry;
    logic valid;
  } stage_cv_t;

  // Segment width per stage, or 0 when the parameter set is illegal.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages,
                                            input int unsigned blk);
    if (stages == 0 || blk == 0 || width == 0) return 0;
    if ((width % (stages * blk)) != 0) return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/csa_segment.sv
// Combinational SEG-bit carry-select segment built from BLK-bit blocks.
module csa_segment #(
  parameter int unsigned SEG = 16,
  parameter int unsigned BLK = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);
  localparam int unsigned NBLK = SEG / BLK;

  logic [BLK:0] w_r0 [NBLK];
  logic [BLK:0] w_r1 [NBLK];
  logic         w_c;

  // Each block resolves both carry-in cases in parallel; only the mux chain is serial.
  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    assign w_r0[j] = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
    assign w_r1[j] = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]} + (BLK+1)'(1);
  end

  always_comb begin
    w_c = ci;
    s   = '0;
    for (int unsigned j = 0; j < NBLK; j++) begin
      s[j*BLK +: BLK] = w_c ? w_r1[j][BLK-1:0] : w_r0[j][BLK-1:0];
      w_c             = w_c ? w_r1[j][BLK] : w_r0[j][BLK];
    end
    co = w_c;
  end

  assign c_msb_in = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// One SEG-bit segment per stage; operands skew forward, result bits deskew forward.
module pipelined_csa_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned BLK    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned SEG = seg_width(WIDTH, STAGES, BLK);

  if (SEG == 0) begin : g_param_err
    $error("pipelined_csa_adder: WIDTH must be a non-zero multiple of STAGES*BLK");
  end

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_bx  [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_sub [STAGES];
  stage_cv_t        r_cv  [STAGES];
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_bx_in  [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic             w_sub_in [STAGES];
  logic             w_ci     [STAGES];
  logic             w_ld     [STAGES];
  logic             w_co     [STAGES];
  logic             w_cmsb   [STAGES];
  logic [SEG-1:0]   w_s      [STAGES];
  logic             w_adv;

  assign w_adv    = ~r_cv[STAGES-1].valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_in[k]   = a;
      assign w_bx_in[k]  = sub ? ~b : b;
      assign w_sum_in[k] = '0;
      assign w_sub_in[k] = sub;
      assign w_ci[k]     = sub ? ~cin : cin;
      assign w_ld[k]     = in_valid;
    end else begin : g_body
      assign w_a_in[k]   = r_a[k-1];
      assign w_bx_in[k]  = r_bx[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_sub_in[k] = r_sub[k-1];
      assign w_ci[k]     = r_cv[k-1].carry;
      assign w_ld[k]     = r_cv[k-1].valid;
    end

    csa_segment #(
      .SEG(SEG),
      .BLK(BLK)
    ) u_seg (
      .a       (w_a_in[k][k*SEG +: SEG]),
      .b       (w_bx_in[k][k*SEG +: SEG]),
      .ci      (w_ci[k]),
      .s       (w_s[k]),
      .co      (w_co[k]),
      .c_msb_in(w_cmsb[k])
    );
  end

  // Bubbles advance the valid bit but leave the data registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_bx[k]  <= '0;
        r_sum[k] <= '0;
        r_sub[k] <= 1'b0;
        r_cv[k]  <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_cv[k].valid <= w_ld[k];
        if (w_ld[k]) begin
          r_a[k]                 <= w_a_in[k];
          r_bx[k]                <= w_bx_in[k];
          r_sub[k]               <= w_sub_in[k];
          r_sum[k]               <= w_sum_in[k];
          r_sum[k][k*SEG +: SEG] <= w_s[k];
          r_cv[k].carry          <= w_co[k];
        end
      end
      if (w_ld[STAGES-1]) begin
        r_ovf <= w_cmsb[STAGES-1] ^ w_co[STAGES-1];
      end
    end
  end

  assign out_valid = r_cv[STAGES-1].valid;
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_cv[STAGES-1].carry ^ r_sub[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Bench for pipelined_csa_adder: directed cases, back-pressure, random streaming
// on three parameter sets, and reset with beats in flight.
module tb_pipelined_csa_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // d0: 16/4/4, d1: 16/1/4, d2: 64/8/8
  logic        d0_in_valid, d0_in_ready, d0_cin, d0_sub, d0_out_valid, d0_out_ready;
  logic        d0_cout, d0_ovf;
  logic [15:0] d0_a, d0_b, d0_sum;
  logic        d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready;
  logic        d1_cout, d1_ovf;
  logic [15:0] d1_a, d1_b, d1_sum;
  logic        d2_in_valid, d2_in_ready, d2_cin, d2_sub, d2_out_valid, d2_out_ready;
  logic        d2_cout, d2_ovf;
  logic [63:0] d2_a, d2_b, d2_sum;

  pipelined_csa_adder #(.WIDTH(16), .STAGES(4), .BLK(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .a(d0_a), .b(d0_b), .cin(d0_cin), .sub(d0_sub), .out_valid(d0_out_valid),
    .out_ready(d0_out_ready), .sum(d0_sum), .cout(d0_cout), .ovf(d0_ovf)
  );

  pipelined_csa_adder #(.WIDTH(16), .STAGES(1), .BLK(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a(d1_a), .b(d1_b), .cin(d1_cin), .sub(d1_sub), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
  );

  pipelined_csa_adder #(.WIDTH(64), .STAGES(8), .BLK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a(d2_a), .b(d2_b), .cin(d2_cin), .sub(d2_sub), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .sum(d2_sum), .cout(d2_cout), .ovf(d2_ovf)
  );

  // Random stream shared by all three DUTs (16-bit DUTs use the low half).
  logic [63:0] ta  [100];
  logic [63:0] tb  [100];
  logic        tci [100];
  logic        tsu [100];

  logic [15:0] qs [$];
  logic        qc [$];
  logic        qo [$];
  int          sent, recv;
  logic        new_beat;
  logic [63:0] ms;
  logic        mc, mo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer reference: true sum/difference, unsigned carry/borrow, signed range overflow.
  function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub,
                                    output logic [63:0] s, output logic co, output logic ov);
    logic [66:0]        mask, ua, ub, ur;
    logic signed [66:0] sa, sb, sr, lim, scin;
    mask = (67'd1 << w) - 67'd1;
    ua   = {3'b000, a} & mask;
    ub   = {3'b000, b} & mask;
    ur   = sub ? (ua - ub - 67'(cin)) : (ua + ub + 67'(cin));
    s    = ur[63:0] & mask[63:0];
    co   = sub ? (ua < (ub + 67'(cin))) : ur[w];
    sa   = $signed(ua << (67 - w)) >>> (67 - w);
    sb   = $signed(ub << (67 - w)) >>> (67 - w);
    scin = $signed({66'd0, cin});
    sr   = sub ? (sa - sb - scin) : (sa + sb + scin);
    lim  = 67'sd1 <<< (w - 1);
    ov   = (sr >= lim) || (sr < -lim);
  endfunction

  // One beat on d0 with constant expectations; entered and left just after a rising edge.
  task automatic directed0(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [15:0] es,
                           input logic ec, input logic eo);
    d0_a = a; d0_b = b; d0_cin = cin; d0_sub = sub; d0_in_valid = 1'b1;
    @(posedge clk); #1;
    d0_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, ".early_valid"}, 64'(d0_out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, ".valid"}, 64'(d0_out_valid), 64'd1);
    check({tag, ".sum"},   64'(d0_sum),       64'(es));
    check({tag, ".cout"},  64'(d0_cout),      64'(ec));
    check({tag, ".ovf"},   64'(d0_ovf),       64'(eo));
    @(posedge clk); #1;
  endtask

  task automatic check_tp(input string tag, input int i, input int lat, input int w,
                          input logic v, input logic [63:0] s, input logic c, input logic o);
    logic [63:0] es;
    logic        ec, eo;
    int          j;
    j = i - lat;
    if (j >= 0 && j < 100) begin
      ref_model(w, ta[j], tb[j], tci[j], tsu[j], es, ec, eo);
      check({tag, ".valid"}, 64'(v), 64'd1);
      check({tag, ".sum"},   s,      es);
      check({tag, ".cout"},  64'(c), 64'(ec));
      check({tag, ".ovf"},   64'(o), 64'(eo));
    end else begin
      check({tag, ".idle"}, 64'(v), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    d0_in_valid = 1'b0; d0_a = '0; d0_b = '0; d0_cin = 1'b0; d0_sub = 1'b0; d0_out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0; d1_out_ready = 1'b1;
    d2_in_valid = 1'b0; d2_a = '0; d2_b = '0; d2_cin = 1'b0; d2_sub = 1'b0; d2_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(d0_out_valid), 64'd0);
    check("reset.sum",       64'(d0_sum),       64'd0);
    check("reset.cout",      64'(d0_cout),      64'd0);
    check("reset.ovf",       64'(d0_ovf),       64'd0);
    check("reset.in_ready",  64'(d0_in_ready),  64'd1);
    check("reset.d2_valid",  64'(d2_out_valid), 64'd0);
    rst_n = 1'b1;

    directed0("add",        16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed0("carry_all",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed0("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed0("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b1, 1'b0);

    // Back-pressure: 8 beats, consumer stalls for 3 cycles while the pipe is full.
    sent = 0; recv = 0; new_beat = 1'b1;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      if (new_beat && sent < 8) begin
        d0_a = 16'($urandom); d0_b = 16'($urandom);
        d0_cin = 1'($urandom); d0_sub = 1'($urandom);
        new_beat = 1'b0;
      end
      d0_in_valid  = (sent < 8);
      d0_out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (!d0_out_ready) begin
        check("bp.in_ready_stall", 64'(d0_in_ready),  64'd0);
        check("bp.valid_stall",    64'(d0_out_valid), 64'd1);
      end
      if (d0_out_valid) begin
        if (qs.size() == 0) begin
          check("bp.spurious", 64'(d0_out_valid), 64'd0);
        end else begin
          check("bp.sum",  64'(d0_sum),  64'(qs[0]));
          check("bp.cout", 64'(d0_cout), 64'(qc[0]));
          check("bp.ovf",  64'(d0_ovf),  64'(qo[0]));
          if (d0_out_ready) begin
            void'(qs.pop_front()); void'(qc.pop_front()); void'(qo.pop_front());
            recv++;
          end
        end
      end
      if (d0_in_valid && d0_in_ready) begin
        ref_model(16, 64'(d0_a), 64'(d0_b), d0_cin, d0_sub, ms, mc, mo);
        qs.push_back(ms[15:0]); qc.push_back(mc); qo.push_back(mo);
        sent++;
        new_beat = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("bp.received", 64'(recv), 64'd8);
    d0_in_valid  = 1'b0;
    d0_out_ready = 1'b1;
    @(posedge clk); #1;

    // Full-rate random stream into all three configurations.
    for (int i = 0; i < 100; i++) begin
      ta[i]  = (i % 10 == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      tb[i]  = (i % 10 == 7) ? 64'h0 : {$urandom, $urandom};
      tci[i] = 1'($urandom);
      tsu[i] = 1'($urandom);
    end
    for (int i = 0; i < 110; i++) begin
      check_tp("tp.d0", i, 4, 16, d0_out_valid, 64'(d0_sum), d0_cout, d0_ovf);
      check_tp("tp.d1", i, 1, 16, d1_out_valid, 64'(d1_sum), d1_cout, d1_ovf);
      check_tp("tp.d2", i, 8, 64, d2_out_valid, d2_sum,      d2_cout, d2_ovf);
      if (i < 100) begin
        d0_a = ta[i][15:0]; d0_b = tb[i][15:0]; d0_cin = tci[i]; d0_sub = tsu[i];
        d1_a = ta[i][15:0]; d1_b = tb[i][15:0]; d1_cin = tci[i]; d1_sub = tsu[i];
        d2_a = ta[i];       d2_b = tb[i];       d2_cin = tci[i]; d2_sub = tsu[i];
        d0_in_valid = 1'b1; d1_in_valid = 1'b1; d2_in_valid = 1'b1;
        check("tp.in_ready", 64'(d0_in_ready & d1_in_ready & d2_in_ready), 64'd1);
      end else begin
        d0_in_valid = 1'b0; d1_in_valid = 1'b0; d2_in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Reset with three beats in flight, the oldest already presented at the output.
    for (int k = 0; k < 3; k++) begin
      d0_a = 16'h1234 + 16'(k); d0_b = 16'h1111; d0_cin = 1'b0; d0_sub = 1'b0;
      d0_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    d0_in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst.pre_valid", 64'(d0_out_valid), 64'd1);
    check("rst.pre_sum",   64'(d0_sum),       64'h2345);
    rst_n = 1'b0;
    #1;
    check("rst.valid",    64'(d0_out_valid), 64'd0);
    check("rst.sum",      64'(d0_sum),       64'd0);
    check("rst.cout",     64'(d0_cout),      64'd0);
    check("rst.ovf",      64'(d0_ovf),       64'd0);
    check("rst.in_ready", 64'(d0_in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rst.no_stale", 64'(d0_out_valid), 64'd0);
    end
    directed0("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_csa_adder.md
# pipelined_csa_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface.
- Operands are split into STAGES segments. Each segment is built from BLK-bit carry-select blocks.
- The carry between segments is registered, and operand/result bits are skewed and deskewed so that one operation can be issued per cycle.
- Sits in the arithmetic datapath where a wide add must close timing at high clock rates and tolerate downstream back-pressure.
- Adds subtract-with-borrow and signed-overflow detection.

## Interface
Parameters:
- WIDTH, 64: operand/result width. Must be divisible by STAGES*BLK (elaboration error otherwise).
- STAGES, 4: pipeline stages. Each stage covers SEG = WIDTH/STAGES bits. STAGES ≥ 1.
- BLK, 4: carry-select block width inside a segment.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: block accepts beat this cycle.
- a, in, WIDTH: operand A.
- b, in, WIDTH: operand B.
- cin, in, 1: carry-in (add) / borrow-in (subtract).
- sub, in, 1: 0 = add, 1 = subtract.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts result.
- sum, out, WIDTH: result.
- cout, out, 1: carry-out (add) / borrow-out (subtract).
- ovf, out, 1: two's-complement signed overflow.

## Operation
- Effective operand: bx = sub ? ~b : b.
- Effective carry-in: c0 = sub ? ~cin : cin.
  - Add: result = a + b + cin.
  - Subtract: result = a − b − cin.
- Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] of a and bx using the carry registered by stage k−1 (c0 for stage 0).
  - Within a segment, each BLK block precomputes sum/carry for carry-in 0 and 1. The incoming carry muxes the select chain.
- Operand bits for later stages travel forward through skew registers. Result bits from earlier stages travel forward through deskew registers. All WIDTH result bits appear together.
- Final carry c_out of the MSB:
  - cout = sub ? ~c_out : c_out.
  - ovf = carry into bit WIDTH−1 XOR c_out, computed in the last stage.
- Handshake uses a global pipeline enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
- Per-stage valid bits v[0..STAGES−1]:
  - On adv: v[0] ← in_valid and v[k] ← v[k−1]. Data registers load only when the corresponding valid advances in.
  - out_valid = v[STAGES−1].
- Bubbles are not collapsed. An invalid slot still occupies a stage.
- Stall (adv = 0): every register holds. sum, cout, ovf and out_valid are stable while out_valid & ~out_ready.

## Timing
- Latency is exactly STAGES cycles from the accept edge to out_valid, when not stalled.
- Throughput is 1 result per cycle with out_ready held high.
- Output is registered. The combinational path per stage is one SEG-bit carry-select segment plus the mux.
- in_ready depends combinationally on out_ready and out_valid only. There is no path from in_valid to in_ready.
- Reset (rst_n low, asynchronous): all v = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. All data, skew and carry registers are 0. In-flight beats are discarded. in_ready = 1 immediately after reset.
- Reset deassertion takes effect at the next rising edge. The first acceptance is possible on that edge.
- Simultaneous accept and output consume in the same cycle is legal and required for full throughput.
- Sign and mode wrap-around: results are modulo 2^WIDTH. Carry and borrow are reported only through cout.

## Structure
- Shared package pipe_adder_pkg holds:
  - a helper function computing SEG and checking the parameter constraints;
  - a typedef for the stage carry/valid pair.
- Sub-module csa_segment (parameters SEG, BLK) is the combinational SEG-bit carry-select segment. Ports: a, b, ci, s, co, c_msb_in. It is instantiated STAGES times via a generate loop.
- The top level contains the valid chain, skew/deskew registers and output logic.

## Test plan
- Add: WIDTH=16, STAGES=4, BLK=4, a=0x00FF, b=0x0001, cin=0 → after 4 cycles sum=0x0100, cout=0, ovf=0.
- Carry across all stages: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Also a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007, cin=1 → sum=0xFFFD, cout=1 (borrow), ovf=0.
- Back-pressure: stream 8 beats with out_ready low for 3 cycles mid-stream. Check in_ready=0 during the stall, results are held stable, and no beat is lost or duplicated, in order.
- Throughput: out_ready=1 and 100 random back-to-back beats → one result per cycle after 4-cycle latency, all matching the reference model. Repeat with STAGES=1 and with WIDTH=64, STAGES=8, BLK=8.
- Reset mid-operation: assert rst_n low with 3 beats in flight. Check out_valid=0 and sum=0 at once. After release, no stale results appear and the next beat returns correctly.
